sum64_seq: RTL
==============

Name: sum64_seq

Overview:
Multi-cycle WIDTH-bit adder controller that time-shares one existing sum4 ripple slice across all nibbles of the operands.
- Accepts one operand pair through a valid/ready handshake.
- Feeds one nibble per clock into sum4, least-significant nibble first, and registers the inter-nibble carry.
- Presents the full sum and carry-out through a second valid/ready handshake.
- Sits in Sum64 as the area-minimal alternative to a fully unrolled 64-bit adder.

Parameters:
WIDTH, 64, operand width in bits; must be a multiple of 4 and at least 8 (elaboration-time assertion).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand pair and cin are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  sum and cout are valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.
busy  output  1  high in RUN or DONE.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, sum 0, cout 0, nibble counter 0, carry register 0, operand registers 0.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, capture a→opa, b→opb, cin→carry, cnt=0, and go to RUN.
  - RUN: in_ready=0. sum4 inputs are opa[3:0], opb[3:0] and carry. Each edge:
    - shift opa and opb right by 4;
    - shift the sum4 result nibble into the top of the sum shift register;
    - carry ← sum4 cout;
    - cnt++.
    - On the edge where cnt==WIDTH/4-1, go to DONE and set cout ← sum4 cout.
  - DONE: out_valid=1. sum and cout are stable. On out_valid&out_ready, go to IDLE and drop out_valid.
- Latency: with the accept edge as edge 0, out_valid is high after edge WIDTH/4 (edge 16 for WIDTH=64).
- Throughput: with in_valid and out_ready held high, one result every WIDTH/4+2 cycles (18 for WIDTH=64).
- in_ready is 0 in RUN and DONE. in_valid is ignored there, and a, b and cin may change freely.
- Backpressure: out_valid stays high and sum/cout stay unchanged while out_ready=0, with no timeout.
- Simultaneous in_valid and out_ready in DONE: the result handshake completes first. The new operands are not accepted until the IDLE cycle that follows.
- sum and cout are defined only while out_valid=1. During RUN the sum register holds partial shifted data.
- Arithmetic: cout=1 exactly when a+b+cin ≥ 2^WIDTH. Unsigned; no overflow flag.
- Reset mid-operation: aborts immediately. All registers take their reset values and no partial result is emitted. The first operation after reset release is fully correct.
- out_valid and in_ready come directly from state decode and are glitch-free registered-state outputs. There are no combinational paths from in_valid or out_ready to any output.

Decomposition:
- Package sum_pkg:
  - NIB_W=4;
  - state enum seq_state_t {IDLE, RUN, DONE};
  - function nibbles(width) returning width/NIB_W, used for the counter width $clog2(WIDTH/4).
- One sub-module: an existing sum4 instance (u_slice) as the sole adder datapath. No other arithmetic in the controller apart from the counter increment.

Test Plan:
- Carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0, cout=1; out_valid rises exactly 16 cycles after the accept edge.
- Nibble alignment: a=64'h0123_4567_89AB_CDEF, b=64'hFEDC_BA98_7654_3210, cin=0 → sum=64'hFFFF_FFFF_FFFF_FFFF, cout=0. Same operands with cin=1 → sum=0, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b → sum/cout unchanged, in_ready=0, no operand captured. Then out_ready=1 → IDLE next cycle.
- Reset mid-RUN: assert rst_n=0 at RUN cycle 7 → out_valid=0, sum=0, busy=0 immediately. After release, run a=5, b=7, cin=1 → sum=13, cout=0.
- Back-to-back: stream 100 random pairs with in_valid and out_ready held 1, comparing against a+b+cin → all match, accept edges exactly 18 cycles apart.
- Parameter: WIDTH=16, a=16'h8000, b=16'h8000, cin=0 → sum=0, cout=1, latency 4 cycles.

Source files
------------

// File: rtl/sum_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package sum_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Number of nibbles in an operand of the given width.
  function automatic int unsigned nibbles(input int unsigned width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/sum4.sv
// 4-bit ripple-carry adder slice.
module sum4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  // One full adder per bit, carry rippling upward.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/sum64_seq.sv
// Multi-cycle WIDTH-bit adder: one sum4 slice reused for every nibble,
// least-significant nibble first, with a registered inter-nibble carry.
module sum64_seq
  import sum_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NIBS  = nibbles(WIDTH);
  localparam int unsigned CNT_W = $clog2(NIBS);

  if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_width_check
    $error("sum64_seq: WIDTH must be a multiple of 4 and at least 8");
  end

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  assign last = (cnt == CNT_W'(NIBS - 1));

  sum4 u_slice (
    .a    (opa[NIB_W-1:0]),
    .b    (opb[NIB_W-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: accept in IDLE, step nibbles in RUN, hold result in DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, nibble shift, carry chain and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          // Result nibbles enter at the top; after NIBS shifts the first
          // nibble computed has reached bit 0.
          opa   <= opa >> NIB_W;
          opb   <= opb >> NIB_W;
          sum_r <= {slice_sum, sum_r[WIDTH-1:NIB_W]};
          carry <= slice_cout;
          cnt   <= cnt + CNT_W'(1);
          if (last) cout_r <= slice_cout;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule
